// File: rtl/mac_vector_unit.sv
// N_LANES-wide fixed-point multiply-accumulate engine: broadcast activation, per-lane weight and bias,
// full-precision guarded accumulation, then round / saturate / optional ReLU on the final term.
module mac_vector_unit #(
    parameter int Q_INT     = 8,
    parameter int Q_FRAC    = 8,
    parameter int N_LANES   = 4,
    parameter int ACC_GUARD = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic                        relu_en,
    input  logic [Q_INT+Q_FRAC-1:0]     x,
    input  logic [N_LANES*(Q_INT+Q_FRAC)-1:0] w,
    input  logic [N_LANES*(Q_INT+Q_FRAC)-1:0] bias,
    output logic                        out_valid,
    output logic [N_LANES*(Q_INT+Q_FRAC)-1:0] out_data,
    output logic [N_LANES-1:0]          out_sat,
    output logic                        busy
);

    localparam int Q_SIZE = Q_INT + Q_FRAC;
    localparam int PROD_W = 2 * Q_SIZE;
    localparam int ACC_W  = PROD_W + ACC_GUARD;

    // One extra MSB on the rounding path so adding the half-LSB can never wrap.
    localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(1) <<< (Q_FRAC - 1);
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((2 ** (Q_SIZE - 1)) - 1);
    localparam logic signed [ACC_W:0] MIN_V = (ACC_W+1)'(-(2 ** (Q_SIZE - 1)));

    // Stage 1: products plus the control bits that travel with them
    logic                     r_s1_valid;
    logic                     r_s1_first;
    logic                     r_s1_last;
    logic                     r_s1_relu;
    logic signed [PROD_W-1:0] r_prod    [N_LANES];
    logic signed [Q_SIZE-1:0] r_s1_bias [N_LANES];

    // Stage 2: accumulators
    logic                     r_s2_valid;
    logic                     r_s2_last;
    logic                     r_s2_relu;
    logic signed [ACC_W-1:0]  r_acc     [N_LANES];

    // Stage 3: output registers
    logic                          r_out_valid;
    logic [N_LANES*Q_SIZE-1:0]     r_out_data;
    logic [N_LANES-1:0]            r_out_sat;

    // A dot product has seen its first term but not yet its last
    logic                     r_open;

    logic signed [PROD_W-1:0] w_prod     [N_LANES];
    logic signed [ACC_W-1:0]  w_bias_ext [N_LANES];
    logic signed [ACC_W-1:0]  w_acc_next [N_LANES];
    logic signed [ACC_W:0]    w_sum      [N_LANES];
    logic signed [ACC_W:0]    w_rnd      [N_LANES];
    logic [Q_SIZE-1:0]        w_res      [N_LANES];
    logic [N_LANES-1:0]       w_sat;

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        w_sat = '0;
        for (int i = 0; i < N_LANES; i++) begin
            w_prod[i]     = PROD_W'($signed(x)) * PROD_W'($signed(w[i*Q_SIZE +: Q_SIZE]));
            w_bias_ext[i] = ACC_W'(r_s1_bias[i]) <<< Q_FRAC;
            w_acc_next[i] = (r_s1_first ? w_bias_ext[i] : r_acc[i]) + ACC_W'(r_prod[i]);

            w_sum[i]      = (ACC_W+1)'(r_acc[i]) + HALF;
            w_rnd[i]      = w_sum[i] >>> Q_FRAC;
            w_res[i]      = w_rnd[i][Q_SIZE-1:0];
            if (w_rnd[i] > MAX_V) begin
                w_res[i] = MAX_V[Q_SIZE-1:0];
                w_sat[i] = 1'b1;
            end else if (w_rnd[i] < MIN_V) begin
                w_res[i] = MIN_V[Q_SIZE-1:0];
                w_sat[i] = 1'b1;
            end
            // ReLU wins over saturation: a clamped negative result becomes a clean zero
            if (r_s2_relu && w_rnd[i][ACC_W]) begin
                w_res[i] = '0;
                w_sat[i] = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_relu   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_relu   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
            r_open      <= 1'b0;
            // NOTE: the per-lane arrays are registers, not RAM, so clearing them in reset is cheap and required.
            for (int i = 0; i < N_LANES; i++) begin
                r_prod[i]    <= '0;
                r_s1_bias[i] <= '0;
                r_acc[i]     <= '0;
            end
        end else begin
            r_s1_valid <= in_valid;
            r_s1_first <= in_valid & in_first;
            r_s1_last  <= in_valid & in_last;
            r_s1_relu  <= relu_en;
            for (int i = 0; i < N_LANES; i++) begin
                r_prod[i]    <= w_prod[i];
                r_s1_bias[i] <= $signed(bias[i*Q_SIZE +: Q_SIZE]);
            end

            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_valid & r_s1_last;
            r_s2_relu  <= r_s1_relu;
            if (r_s1_valid) begin
                for (int i = 0; i < N_LANES; i++) begin
                    r_acc[i] <= w_acc_next[i];
                end
            end

            r_out_valid <= r_s2_valid & r_s2_last;
            if (r_s2_valid && r_s2_last) begin
                for (int i = 0; i < N_LANES; i++) begin
                    r_out_data[i*Q_SIZE +: Q_SIZE] <= w_res[i];
                end
                r_out_sat <= w_sat;
            end

            if (in_valid) begin
                if (in_last) begin
                    r_open <= 1'b0;
                end else if (in_first) begin
                    r_open <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign busy      = r_s1_valid | r_s2_valid | r_out_valid | r_open;

endmodule

// File: tb/tb_mac_vector_unit.sv
// Scoreboard bench for mac_vector_unit at Q8.8, 4 lanes: directed vectors, a streaming
// section checked against a small arithmetic model, and a mid-product reset.
module tb_mac_vector_unit;

    localparam int QS = 16;
    localparam int NL = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_first = 1'b0;
    logic              in_last  = 1'b0;
    logic              relu_en  = 1'b0;
    logic [QS-1:0]     x_in     = '0;
    logic [NL*QS-1:0]  w_bus    = '0;
    logic [NL*QS-1:0]  bias_bus = '0;
    logic              out_valid;
    logic [NL*QS-1:0]  out_data;
    logic [NL-1:0]     out_sat;
    logic              busy;

    mac_vector_unit dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_first (in_first),
        .in_last  (in_last),
        .relu_en  (relu_en),
        .x        (x_in),
        .w        (w_bus),
        .bias     (bias_bus),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NL*QS-1:0] data;
        logic [NL-1:0]    sat;
        int               cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   issue_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest expectation, three cycles after its last beat
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_sat", 64'(out_sat), 64'(e.sat));
                check("latency", 64'(cyc - e.cyc), 64'd3);
            end
        end
    end

    function automatic logic [NL*QS-1:0] rep(input logic [QS-1:0] v);
        return {NL{v}};
    endfunction

    task automatic beat(input bit f, input bit l, input bit r, input logic [QS-1:0] xv,
                        input logic [NL*QS-1:0] wv, input logic [NL*QS-1:0] bv);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_first  = f;
        in_last   = l;
        relu_en   = r;
        x_in      = xv;
        w_bus     = wv;
        bias_bus  = bv;
        issue_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_first = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic push(input logic [NL*QS-1:0] d, input logic [NL-1:0] s);
        exp_t e;
        e.data = d;
        e.sat  = s;
        e.cyc  = issue_cyc;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (n >= 60) check("drain_timeout", 64'd1, 64'd0);
        #1;
    endtask

    // Reference arithmetic for the streaming section, in plain integer terms
    longint m_acc [NL];

    task automatic model_beat(input bit f, input bit l, input bit r, input logic [QS-1:0] xv,
                              input logic [NL*QS-1:0] wv, input logic [NL*QS-1:0] bv);
        logic [NL*QS-1:0] d;
        logic [NL-1:0]    s;
        longint           res;
        logic [QS-1:0]    wl;
        logic [QS-1:0]    bl;
        beat(f, l, r, xv, wv, bv);
        d = '0;
        s = '0;
        for (int i = 0; i < NL; i++) begin
            wl = wv[i*QS +: QS];
            bl = bv[i*QS +: QS];
            if (f) m_acc[i] = longint'($signed(bl)) * 256;
            m_acc[i] = m_acc[i] + longint'($signed(xv)) * longint'($signed(wl));
            if (l) begin
                res = (m_acc[i] + 128) >>> 8;
                if (res > 32767) begin
                    d[i*QS +: QS] = 16'h7FFF;
                    s[i] = 1'b1;
                end else if (res < -32768) begin
                    d[i*QS +: QS] = 16'h8000;
                    s[i] = 1'b1;
                end else begin
                    d[i*QS +: QS] = res[QS-1:0];
                end
                if (r && res < 0) begin
                    d[i*QS +: QS] = '0;
                    s[i] = 1'b0;
                end
            end
        end
        if (l) push(d, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_out_sat", 64'(out_sat), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // Single term: 0.25 + 1.0*2.5 = 2.75
        beat(1, 1, 0, 16'h0100, rep(16'h0280), rep(16'h0040));
        push(rep(16'h02C0), 4'b0000);
        idle(1);
        drain();

        // Headroom: 100+100-100-50 = 50 without an intermediate clamp; dot product stays open over a gap
        beat(1, 0, 0, 16'h0100, rep(16'h6400), rep(16'h0000));
        beat(0, 0, 0, 16'h0100, rep(16'h6400), rep(16'h0000));
        idle(4);
        check("busy_open_product", 64'(busy), 64'd1);
        beat(0, 0, 0, 16'h0100, rep(16'h9C00), rep(16'h0000));
        beat(0, 1, 0, 16'h0100, rep(16'hCE00), rep(16'h0000));
        push(rep(16'h3200), 4'b0000);
        idle(1);
        drain();

        // Saturation, back-to-back with no bubble
        beat(1, 1, 0, 16'h7F00, rep(16'h7F00), rep(16'h0000));
        push(rep(16'h7FFF), 4'b1111);
        beat(1, 1, 0, 16'h8000, rep(16'h7F00), rep(16'h0000));
        push(rep(16'h8000), 4'b1111);
        // Per-lane: 127*{1,2,-1,-2} -> only lanes 1 and 3 clamp
        beat(1, 1, 0, 16'h7F00, {16'hFE00, 16'hFF00, 16'h0200, 16'h0100}, rep(16'h0000));
        push({16'h8000, 16'h8100, 16'h7FFF, 16'h7F00}, 4'b1010);

        // Rounding at the half-LSB boundary
        beat(1, 1, 0, 16'h0001, rep(16'h0080), rep(16'h0000));
        push(rep(16'h0001), 4'b0000);
        beat(1, 1, 0, 16'h0001, rep(16'h0040), rep(16'h0000));
        push(rep(16'h0000), 4'b0000);
        beat(1, 1, 0, 16'hFFFF, rep(16'h0080), rep(16'h0000));
        push(rep(16'h0000), 4'b0000);

        // ReLU on a -3.0 result, with and without clamp
        beat(1, 1, 1, 16'h0100, rep(16'hFD00), rep(16'h0000));
        push(rep(16'h0000), 4'b0000);
        beat(1, 1, 0, 16'h0100, rep(16'hFD00), rep(16'h0000));
        push(rep(16'hFD00), 4'b0000);
        // ReLU also clears the saturation flag of a clamped negative result
        beat(1, 1, 1, 16'h8000, rep(16'h7F00), rep(16'h0100));
        push(rep(16'h0000), 4'b0000);
        idle(1);
        drain();

        // Streaming: random lengths, random bubbles, random operands and ReLU
        for (int p = 0; p < 12; p++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int t = 0; t < len; t++) begin
                logic [NL*QS-1:0] wv;
                logic [NL*QS-1:0] bv;
                logic [QS-1:0]    xv;
                xv = 16'($urandom);
                wv = {$urandom, $urandom};
                bv = {$urandom, $urandom};
                model_beat(t == 0, t == len - 1, 1'($urandom_range(0, 1)), xv, wv, bv);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        idle(1);
        drain();

        // Reset in the middle of a dot product: nothing emerges and the accumulator is cleared
        beat(1, 0, 0, 16'h0100, rep(16'h0500), rep(16'h0300));
        beat(0, 1, 0, 16'h0100, rep(16'h0500), rep(16'h0000));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        repeat (4) begin
            @(negedge clk);
            check("rst_no_stale_out", 64'(out_valid), 64'd0);
        end
        // No-flag beat accumulates onto the cleared acc: 0 + 2.0 + 1.0
        beat(0, 0, 0, 16'h0100, rep(16'h0200), rep(16'h7777));
        beat(0, 1, 0, 16'h0100, rep(16'h0100), rep(16'h7777));
        push(rep(16'h0300), 4'b0000);
        idle(1);
        drain();
        check("out_hold_data", out_data, rep(16'h0300));

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
